// File: rtl/tpu_pkg.sv
// Shared constants, state encoding and lane/word slice helpers for the TPU tile sequencer.
package tpu_pkg;

    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int WORD_W = LANES * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_OUT
    } state_t;

    typedef logic [WORD_W-1:0]            word_t;
    typedef logic [LANES-1:0][WORD_W-1:0] quad_t;

    function automatic logic [DATA_W-1:0] lane_get(input word_t w, input logic [1:0] i);
        return DATA_W'(w >> (DATA_W * int'(i)));
    endfunction

    function automatic word_t lane_set(input word_t w, input logic [1:0] i,
                                       input logic [DATA_W-1:0] b);
        word_t mask;
        mask = word_t'({DATA_W{1'b1}}) << (DATA_W * int'(i));
        return (w & ~mask) | (word_t'(b) << (DATA_W * int'(i)));
    endfunction

    function automatic word_t word_get(input quad_t q, input logic [1:0] k);
        return q[k];
    endfunction

endpackage

// File: rtl/tpu_skew.sv
// Diagonal feed for the systolic array: lane i carries vector (c-i) during RUN, zero otherwise.
module tpu_skew
    import tpu_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  quad_t            vecs,
    output word_t            data_arr
);

    int v;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        data_arr = '0;
        v        = 0;
        for (int i = 0; i < LANES; i++) begin
            v = int'(cnt) - i;
            if (run && v >= 0 && v < LANES)
                data_arr = lane_set(data_arr, 2'(i), lane_get(vecs[2'(v)], 2'(i)));
        end
    end

endmodule

// File: rtl/tpu_sequencer.sv
// Tile job sequencer for a 4x4 weight-stationary TPU: buffers weights and data, loads, feeds, collects results.
// Optional weight reuse between jobs is enabled with `define TPU_SEQ_WT_REUSE_EN (adds the keep_wt input).
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int OUT_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef TPU_SEQ_WT_REUSE_EN
    input  logic              keep_wt,
`endif
    input  logic [WORD_W-1:0] wt_in,
    input  logic              wt_valid,
    output logic              wt_ready,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tpu_control,
    output logic [WORD_W-1:0] tpu_wt_arr,
    output logic [WORD_W-1:0] tpu_data_arr,
    input  logic [ACC_W-1:0]  pe30_out,
    input  logic [ACC_W-1:0]  pe31_out,
    input  logic [ACC_W-1:0]  pe32_out,
    input  logic [ACC_W-1:0]  pe33_out,
    output logic [LANES*ACC_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
);

    localparam int LAST_C = 6 + OUT_LAT;
    localparam int CNT_W  = $clog2(LAST_C + 1);

    state_t                              state, next_state;
    logic [2:0]                          wt_cnt, din_cnt;
    logic [CNT_W-1:0]                    cnt;
    logic [1:0]                          row;
    quad_t                               wt_buf, din_buf;
    logic [LANES-1:0][LANES-1:0][ACC_W-1:0] res_buf;
    logic [LANES-1:0][ACC_W-1:0]         pe;
    logic                                keep_q;
    logic                                wt_fire, din_fire, wt_full_nxt, din_full_nxt;

    assign pe = {pe33_out, pe32_out, pe31_out, pe30_out};

`ifdef TPU_SEQ_WT_REUSE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            keep_q <= 1'b0;
        else if (state == S_IDLE && start)
            keep_q <= keep_wt;
    end
`else
    assign keep_q = 1'b0;
`endif

    // Readies depend only on registered state, keeping the handshake free of combinational loops.
    assign wt_ready     = (state == S_FILL) && !keep_q && (wt_cnt != 3'd4);
    assign din_ready    = (state == S_FILL) && (din_cnt != 3'd4);
    assign wt_fire      = wt_valid && wt_ready;
    assign din_fire     = din_valid && din_ready;
    assign wt_full_nxt  = (wt_cnt == 3'd4) || (wt_cnt == 3'd3 && wt_fire);
    assign din_full_nxt = (din_cnt == 3'd4) || (din_cnt == 3'd3 && din_fire);
    assign busy         = (state != S_IDLE);
    assign res_data     = (state == S_OUT) ? res_buf[row] : '0;

    always_comb begin
        next_state  = state;
        tpu_control = 1'b0;
        tpu_wt_arr  = '0;
        res_valid   = 1'b0;
        case (state)
            S_IDLE: if (start) next_state = S_FILL;
            S_FILL: begin
                if ((keep_q || wt_full_nxt) && din_full_nxt)
                    next_state = keep_q ? S_RUN : S_LOAD;
            end
            S_LOAD: begin
                tpu_control = 1'b1;
                tpu_wt_arr  = word_get(wt_buf, cnt[1:0]);
                if (cnt[1:0] == 2'd3) next_state = S_SETTLE;
            end
            S_SETTLE: begin
                tpu_control = 1'b1;
                next_state  = S_RUN;
            end
            S_RUN: if (cnt == CNT_W'(LAST_C)) next_state = S_OUT;
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready && row == 2'd3) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            wt_cnt  <= '0;
            din_cnt <= '0;
            cnt     <= '0;
            row     <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE) begin
                wt_cnt  <= '0;
                din_cnt <= '0;
            end else begin
                if (wt_fire)  wt_cnt  <= wt_cnt + 3'd1;
                if (din_fire) din_cnt <= din_cnt + 3'd1;
            end
            if (state != next_state)
                cnt <= '0;
            else if (state == S_LOAD || state == S_RUN)
                cnt <= cnt + CNT_W'(1);
            if (state != S_OUT)
                row <= '0;
            else if (res_ready)
                row <= row + 2'd1;
        end
    end

    // NOTE: buffer storage is not reset; the counts and state gate every use, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (wt_fire)  wt_buf[wt_cnt[1:0]]   <= wt_in;
        if (din_fire) din_buf[din_cnt[1:0]] <= din;
        if (state == S_RUN) begin
            for (int r = 0; r < LANES; r++)
                for (int j = 0; j < LANES; j++)
                    if (int'(cnt) == r + j + OUT_LAT)
                        res_buf[2'(r)][2'(j)] <= pe[2'(j)];
        end
    end

    tpu_skew #(.CNT_W(CNT_W)) u_skew (
        .run      (state == S_RUN),
        .cnt      (cnt),
        .vecs     (din_buf),
        .data_arr (tpu_data_arr)
    );

endmodule

// File: tb/tb_tpu_sequencer.sv
// Randomized self-checking bench for tpu_sequencer with a behavioural TPU and job-level reference model.
module tb_tpu_sequencer;
    import tpu_pkg::*;

    localparam int OUT_LAT = 4;
    localparam int LAST_C  = 6 + OUT_LAT;

    logic        clk = 1'b0;
    logic        rst, start, wt_valid, din_valid, res_ready;
    logic        wt_ready, din_ready, tpu_control, res_valid, busy;
    logic [31:0] wt_in, din, tpu_wt_arr, tpu_data_arr;
    logic [23:0] pe30_out, pe31_out, pe32_out, pe33_out;
    logic [95:0] res_data;
`ifdef TPU_SEQ_WT_REUSE_EN
    logic        keep_wt;
`endif

    int    checks = 0;
    int    errors = 0;
    quad_t tpu_wref = '0;

    always #5 clk = ~clk;

    tpu_sequencer #(.OUT_LAT(OUT_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef TPU_SEQ_WT_REUSE_EN
        .keep_wt      (keep_wt),
`endif
        .wt_in        (wt_in),
        .wt_valid     (wt_valid),
        .wt_ready     (wt_ready),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .tpu_control  (tpu_control),
        .tpu_wt_arr   (tpu_wt_arr),
        .tpu_data_arr (tpu_data_arr),
        .pe30_out     (pe30_out),
        .pe31_out     (pe31_out),
        .pe32_out     (pe32_out),
        .pe33_out     (pe33_out),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural TPU: the k-th control cycle loads PE column 3-k; pe3j sees lane i delayed by OUT_LAT+j-i cycles.
    logic [31:0] hist[$];
    logic [31:0] tw [4] = '{default: '0};
    logic [23:0] pe_m [4] = '{default: '0};
    int          lk = 0;

    assign pe30_out = pe_m[0];
    assign pe31_out = pe_m[1];
    assign pe32_out = pe_m[2];
    assign pe33_out = pe_m[3];

    always @(negedge clk) begin
        int          n, idx;
        logic [23:0] s;
        hist.push_back(tpu_data_arr);
        n = hist.size() - 1;
        if (tpu_control === 1'b1) begin
            if (lk < 4) tw[3 - lk] = tpu_wt_arr;
            lk++;
        end else begin
            lk = 0;
        end
        for (int j = 0; j < 4; j++) begin
            s = '0;
            for (int i = 0; i < 4; i++) begin
                idx = n - OUT_LAT - j + i;
                if (idx >= 0)
                    s += 24'(lane_get(tw[j], 2'(i))) * 24'(lane_get(hist[idx], 2'(i)));
            end
            pe_m[j] = s;
        end
    end

    function automatic logic [31:0] skew_ref(input quad_t d, input int c);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            if (c - i >= 0 && c - i <= 3)
                w |= 32'(lane_get(d[2'(c - i)], 2'(i))) << (8 * i);
        return w;
    endfunction

    // Row r, lane j = dot product of vector r with weight column 3-j.
    function automatic logic [95:0] row_ref(input quad_t d, input quad_t w, input int r);
        logic [95:0] o;
        int          s;
        o = '0;
        for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int i = 0; i < 4; i++)
                s += int'(lane_get(d[2'(r)], 2'(i))) * int'(lane_get(w[2'(3 - j)], 2'(i)));
            o |= 96'(s) << (24 * j);
        end
        return o;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rdy"}, {wt_ready, din_ready}, 2'b00);
        check({tag, "_ctrl"}, tpu_control, 1'b0);
        check({tag, "_wt"}, tpu_wt_arr, 32'h0);
        check({tag, "_data"}, tpu_data_arr, 32'h0);
        check({tag, "_rv"}, res_valid, 1'b0);
        check({tag, "_rd"}, res_data, 96'h0);
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random. stall_row: -2 none, -1 random, else stall that row.
    task automatic run_job(input quad_t w, input quad_t d, input bit keep, input int vmode,
                           input int stall_row, input int stall_len, input int abort_c);
        int wc, dc, guard, stall;
        bit wf, df;
        wc = 0; dc = 0; guard = 0;
        @(negedge clk);
        start = 1'b1;
`ifdef TPU_SEQ_WT_REUSE_EN
        keep_wt = keep;
`endif
        check("idle_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("fill_busy", busy, 1'b1);
        while (!((keep || wc == 4) && dc == 4)) begin
            if (guard > 200) begin
                check("fill_progress", {wc[7:0], dc[7:0]}, {(keep ? 8'd0 : 8'd4), 8'd4});
                break;
            end
            check("wt_ready", wt_ready, !keep && wc < 4);
            check("din_ready", din_ready, dc < 4);
            check("fill_ctrl", tpu_control, 1'b0);
            start = 1'($urandom_range(0, 1));
            case (vmode)
                0:       begin wt_valid = 1'b1; din_valid = 1'b1; end
                1:       begin wt_valid = (guard % 2 == 0); din_valid = (guard % 2 == 1); end
                default: begin wt_valid = 1'($urandom_range(0, 1)); din_valid = 1'($urandom_range(0, 1)); end
            endcase
            wt_in = (wc < 4) ? w[2'(wc)] : $urandom;
            din   = (dc < 4) ? d[2'(dc)] : $urandom;
            wf = wt_valid && !keep && wc < 4;
            df = din_valid && dc < 4;
            guard++;
            @(negedge clk);
            if (wf) wc++;
            if (df) dc++;
        end
        wt_valid = 1'b0; din_valid = 1'b0; start = 1'b0;
        if (!keep) begin
            for (int k = 0; k < 4; k++) begin
                check("load_ctrl", tpu_control, 1'b1);
                check("load_wt", tpu_wt_arr, w[2'(k)]);
                check("load_rdy", {wt_ready, din_ready}, 2'b00);
                @(negedge clk);
            end
            check("settle_ctrl", tpu_control, 1'b1);
            check("settle_wt", tpu_wt_arr, 32'h0);
            @(negedge clk);
            tpu_wref = w;
        end
        for (int c = 0; c <= LAST_C; c++) begin
            check("run_ctrl", tpu_control, 1'b0);
            check("run_data", tpu_data_arr, skew_ref(d, c));
            check("run_rv", res_valid, 1'b0);
            if (c == abort_c) begin
                rst = 1'b1;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
        for (int r = 0; r < 4; r++) begin
            if (stall_row == -1)     stall = $urandom_range(0, 2);
            else if (stall_row == r) stall = stall_len;
            else                     stall = 0;
            for (int s = 0; s <= stall; s++) begin
                res_ready = (s == stall);
                check("out_valid", res_valid, 1'b1);
                check("out_data", res_data, row_ref(d, tpu_wref, r));
                check("out_ctrl", tpu_control, 1'b0);
                @(negedge clk);
            end
        end
        res_ready = 1'b0;
        check("done_busy", busy, 1'b0);
        check("done_rv", res_valid, 1'b0);
    endtask

    function automatic quad_t rand_quad();
        quad_t q;
        for (int k = 0; k < 4; k++) q[k] = $urandom;
        return q;
    endfunction

    initial begin
        quad_t wa, da;
        rst = 1'b1; start = 1'b0; wt_valid = 1'b0; din_valid = 1'b0; res_ready = 1'b0;
        wt_in = '0; din = '0;
`ifdef TPU_SEQ_WT_REUSE_EN
        keep_wt = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        wa = {32'h00000002, 32'h00000200, 32'h00020000, 32'h02000000};
        da = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
        run_job(wa, da, 1'b0, 0, -2, 0, -1);
        run_job(wa, da, 1'b0, 1, 1, 10, -1);
        run_job(rand_quad(), rand_quad(), 1'b0, 2, -1, 0, 3);

        wt_valid = 1'b1; din_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_rdy", {wt_ready, din_ready}, 2'b00);
            check("post_rst_busy", busy, 1'b0);
        end
        wt_valid = 1'b0; din_valid = 1'b0;

        run_job(wa, da, 1'b0, 2, -1, 0, -1);
        repeat (6) run_job(rand_quad(), rand_quad(), 1'b0, 2, -1, 0, -1);
`ifdef TPU_SEQ_WT_REUSE_EN
        run_job('0, rand_quad(), 1'b1, 2, -1, 0, -1);
        run_job(rand_quad(), rand_quad(), 1'b0, 0, -2, 0, -1);
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
